cmd_parser: RTL and testbench

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser.sv | 154 +++++++++++++++
 tb/tb_cmd_parser.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cmd_parser.sv
// Command frame parser: HEADER,P1,P2,P3,CHK with 8-bit additive checksum.
// Parameters are published atomically on a good frame and held until stop.
module cmd_parser #(
  parameter logic [7:0]  HEADER  = 8'hAA,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       stop,
  output logic [7:0] para1,
  output logic [7:0] para2,
  output logic [7:0] para3,
  output logic [3:0] data_num,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [7:0]    sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
  logic [3:0]    num_q, num_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    sum;

  assign cnt_inc = cnt_q + CNT_ONE;
  assign sum     = sh1_q + sh2_q + sh3_q;

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    sh3_d   = sh3_q;
    num_d   = num_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          state_d = RECV;
          num_d   = 4'd1;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (stop) begin
          state_d = IDLE;
          num_d   = 4'd0;
        end else if (rx_valid) begin
          cnt_d = '0;
          unique case (num_q)
            4'd1: begin
              sh1_d = rx_data;
              num_d = 4'd2;
            end
            4'd2: begin
              sh2_d = rx_data;
              num_d = 4'd3;
            end
            4'd3: begin
              sh3_d = rx_data;
              num_d = 4'd4;
            end
            default: begin
              if (rx_data == sum) begin
                p1_d    = sh1_q;
                p2_d    = sh2_q;
                p3_d    = sh3_q;
                num_d   = 4'd5;
                state_d = DONE;
              end else begin
                num_d   = 4'd0;
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end
          endcase
        end else if (cnt_inc == CNT_LAST) begin
          // An rx_valid in this cycle would have taken the branch above
          state_d = IDLE;
          num_d   = 4'd0;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        if (stop) begin
          state_d = IDLE;
          num_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        num_d   = 4'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      sh3_q   <= '0;
      num_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      sh3_q   <= sh3_d;
      num_q   <= num_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign para1    = p1_q;
  assign para2    = p2_q;
  assign para3    = p3_q;
  assign data_num = num_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser with TIMEOUT=16.
// Inputs change and outputs are sampled on the falling edge.
module tb_cmd_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] para1, para2, para3;
  logic [3:0] data_num;
  logic       busy, err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int err_base;

  cmd_parser #(
    .HEADER (8'hAA),
    .TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .stop    (stop),
    .para1   (para1),
    .para2   (para2),
    .para3   (para3),
    .data_num(data_num),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (err === 1'b1) err_cnt <= err_cnt + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d,
                       input logic [7:0] e);
    send(a); send(b); send(c); send(d); send(e);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic chk_para(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c);
    check({tag, ".p1"}, 32'(para1), 32'(a));
    check({tag, ".p2"}, 32'(para2), 32'(b));
    check({tag, ".p3"}, 32'(para3), 32'(c));
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    check("rst.num", 32'(data_num), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    chk_para("rst", 8'h00, 8'h00, 8'h00);

    // stop in IDLE has no effect
    pulse_stop();
    check("idle_stop.num", 32'(data_num), 32'd0);

    // good frame with 3-cycle gaps
    err_base = err_cnt;
    send(8'hAA); check("f1.num1", 32'(data_num), 32'd1);
    check("f1.busy", 32'(busy), 32'd1);
    tick(3); send(8'h01); tick(3); send(8'h0A); tick(3); send(8'h03);
    check("f1.num4", 32'(data_num), 32'd4);
    chk_para("f1.partial", 8'h00, 8'h00, 8'h00);
    tick(3); send(8'h0E);
    check("f1.num5", 32'(data_num), 32'd5);
    check("f1.busy5", 32'(busy), 32'd1);
    chk_para("f1", 8'h01, 8'h0A, 8'h03);
    tick(1);
    check("f1.noerr", 32'(err_cnt - err_base), 32'd0);

    // DONE ignores bytes, stop releases it
    frame(8'hAA, 8'h02, 8'h02, 8'h02, 8'h06);
    check("done.num", 32'(data_num), 32'd5);
    check("done.p1", 32'(para1), 32'h01);
    pulse_stop();
    check("stop.num", 32'(data_num), 32'd0);
    check("stop.busy", 32'(busy), 32'd0);
    check("stop.p1", 32'(para1), 32'h01);
    frame(8'hAA, 8'h02, 8'h02, 8'h02, 8'h06);
    check("f2.num", 32'(data_num), 32'd5);
    chk_para("f2", 8'h02, 8'h02, 8'h02);
    pulse_stop();

    // bad checksum
    err_base = err_cnt;
    frame(8'hAA, 8'h01, 8'h0A, 8'h03, 8'h0F);
    check("bad.err", 32'(err), 32'd1);
    check("bad.num", 32'(data_num), 32'd0);
    check("bad.busy", 32'(busy), 32'd0);
    chk_para("bad", 8'h02, 8'h02, 8'h02);
    tick(1);
    check("bad.err_low", 32'(err), 32'd0);
    tick(1);
    check("bad.pulses", 32'(err_cnt - err_base), 32'd1);

    // timeout fires 15 edges after the last byte
    send(8'hAA); send(8'h01);
    tick(14);
    check("to.pre_err", 32'(err), 32'd0);
    check("to.pre_num", 32'(data_num), 32'd2);
    tick(1);
    check("to.err", 32'(err), 32'd1);
    check("to.num", 32'(data_num), 32'd0);
    tick(1);
    check("to.err_low", 32'(err), 32'd0);

    // byte on the would-be timeout edge is accepted
    err_base = err_cnt;
    send(8'hAA); send(8'h01);
    tick(14);
    send(8'h03);
    check("to_byte.num", 32'(data_num), 32'd3);
    check("to_byte.err", 32'(err), 32'd0);

    // stop with a simultaneous byte drops the byte
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    stop     = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    stop     = 1'b0;
    check("rstop.num", 32'(data_num), 32'd0);
    tick(1);
    check("rstop.noerr", 32'(err_cnt - err_base), 32'd0);

    // HEADER inside a frame is data; no byte before a header counts
    frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("junk.num", 32'(data_num), 32'd0);
    check("junk.busy", 32'(busy), 32'd0);
    frame(8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFD);
    check("wrap.num", 32'(data_num), 32'd5);
    chk_para("wrap", 8'hFF, 8'hFF, 8'hFF);
    pulse_stop();
    frame(8'hAA, 8'hAA, 8'h01, 8'h02, 8'hAD);
    check("hdr_data.num", 32'(data_num), 32'd5);
    chk_para("hdr_data", 8'hAA, 8'h01, 8'h02);
    pulse_stop();

    // reset mid-frame
    send(8'hAA); send(8'h01); send(8'h02);
    check("mid.num", 32'(data_num), 32'd3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst.num", 32'(data_num), 32'd0);
    check("mid_rst.busy", 32'(busy), 32'd0);
    check("mid_rst.err", 32'(err), 32'd0);
    chk_para("mid_rst", 8'h00, 8'h00, 8'h00);
    frame(8'hAA, 8'h05, 8'h06, 8'h07, 8'h12);
    check("post.num", 32'(data_num), 32'd5);
    chk_para("post", 8'h05, 8'h06, 8'h07);

    // reset in DONE wins over a byte in the same cycle
    rst      = 1'b1;
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    tick(1);
    rst      = 1'b0;
    rx_valid = 1'b0;
    check("done_rst.num", 32'(data_num), 32'd0);
    check("done_rst.p1", 32'(para1), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
